uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver for the UART datapath. Consumes the 16x oversampling tick from the baud-rate generator.
- Detects start bits, samples each bit at mid-bit, and shifts data in LSB first.
- Optionally checks parity, then checks the stop bit.
- Delivers one parallel word per frame with a one-cycle done strobe and per-frame error flags.

Parameters:
DBIT, 8, data bits per frame; legal range 5-9.
SB_TICK, 16, s_tick count for the stop period; 16/24/32 = 1/1.5/2 stop bits.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset_n  in  1  asynchronous, active-low reset.
s_tick  in  1  oversampling tick from the baud generator; one-clk pulse, 16 per bit period.
rx  in  1  asynchronous serial line; idles high.
dout  out  DBIT  last received data word.
rx_done_tick  out  1  one-clk pulse when a frame completes.
frame_err  out  1  stop bit sampled low in the last completed frame.
parity_err  out  1  parity mismatch in the last completed frame; always 0 when PARITY_EN=0.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Input sync: rx passes through a 2-flop synchronizer; both flops reset to 1. rx_s is the second flop. Input-to-FSM latency is 2 clk.
- Counters:
  - s: 5-bit tick counter.
  - n: bit index counter, sized for DBIT-1.
  - b: DBIT shift register.
  - p: sampled parity bit.
- Reset (async, reset_n=0): state=IDLE, s=0, n=0, b=0, dout=0, rx_done_tick=0, frame_err=0, parity_err=0, busy=0. Takes effect immediately, including mid-frame; no partial word is delivered.
- Ticks: s_tick advances counters only in START/DATA/PARITY/STOP. With no s_tick, state holds.
- IDLE: if rx_s==0, go to START with s=0. Detection does not wait for s_tick.
- START: on s_tick:
  - s==7 and rx_s==0: go to DATA, s=0, n=0.
  - s==7 and rx_s==1: glitch; return to IDLE with no strobe and outputs unchanged.
  - otherwise s++.
- DATA: on s_tick:
  - s==15: b = {rx_s, b[DBIT-1:1]}, s=0. If n==DBIT-1, go to PARITY (PARITY_EN=1) or STOP; else n++.
  - otherwise s++.
- PARITY: on s_tick, s==15: p=rx_s, s=0, go to STOP; otherwise s++.
- STOP: on s_tick, s==SB_TICK-1, all in the same clock edge:
  - go to IDLE;
  - dout=b;
  - rx_done_tick=1 for exactly one clk;
  - frame_err = ~rx_s;
  - parity_err = PARITY_EN & ((^b ^ p) != PARITY_ODD).
  - Otherwise s++.
- Output holding: dout and both error flags update only on the rx_done_tick edge and hold until the next completed frame.
- Framing error: the word is still delivered, with frame_err=1.
- Back-to-back frames: if rx_s is low in the cycle after returning to IDLE, START entry follows on the next clk. No idle gap is required between frames.
- rx_done_tick is combinationally independent of inputs (registered).

Test Plan:
- Setup: s_tick every 8 clk (bit = 128 clk), default params.
- 8N1 frame: send 0xA5 -> exactly one rx_done_tick about 9.5 bit periods plus 2 clk after the start falling edge; dout=0xA5; frame_err=0; parity_err=0; busy falls with the strobe.
- Start glitch: rx low for 3 ticks (24 clk), then high -> no rx_done_tick; busy returns to 0 at the 8th tick; dout unchanged.
- Frame error: send 0x3C with the stop bit driven low -> rx_done_tick; dout=0x3C; frame_err=1. A following clean 0x11 frame clears frame_err to 0.
- Parity (PARITY_EN=1, PARITY_ODD=0):
  - send 0x07 with parity bit 1 -> parity_err=0;
  - send 0x07 with parity bit 0 -> parity_err=1;
  - rerun with PARITY_ODD=1 -> results invert.
- Back-to-back: 0x00 then 0xFF with no idle gap -> two strobes, dout=0x00 then 0xFF, no errors.
- Reset mid-frame: assert reset_n low during data bit 3 -> all outputs 0 and busy=0 immediately. After release, frame 0x5A -> dout=0x5A, no spurious strobe from the aborted frame.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, LSB first, optional parity.
// Delivers one word per frame with a one-cycle done strobe and held error flags.
module uart_rx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  // state  | meaning
  // IDLE   | line idle, waiting for a low level
  // START  | confirming start bit at its midpoint
  // DATA   | sampling data bits at mid-bit, LSB first
  // PARITY | sampling the parity bit
  // STOP   | waiting out the stop period, then delivering the word
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int   NW   = $clog2(DBIT);
  localparam logic PEN  = (PARITY_EN != 0);
  localparam logic PODD = (PARITY_ODD != 0);

  state_t state, state_nxt;
  logic [4:0]      s, s_nxt;
  logic [NW-1:0]   n, n_nxt;
  logic [DBIT-1:0] b, b_nxt;
  logic            p, p_nxt;
  logic [DBIT-1:0] dout_nxt;
  logic            done_nxt, fe_nxt, pe_nxt;
  logic            rx_m, rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      p            <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      state        <= state_nxt;
      s            <= s_nxt;
      n            <= n_nxt;
      b            <= b_nxt;
      p            <= p_nxt;
      dout         <= dout_nxt;
      rx_done_tick <= done_nxt;
      frame_err    <= fe_nxt;
      parity_err   <= pe_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    n_nxt     = n;
    b_nxt     = b;
    p_nxt     = p;
    dout_nxt  = dout;
    done_nxt  = 1'b0;
    fe_nxt    = frame_err;
    pe_nxt    = parity_err;
    case (state)
      IDLE: begin
        // start detection runs at clk rate, not gated by s_tick
        if (!rx_s) begin
          state_nxt = START;
          s_nxt     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == 5'd7) begin
            if (!rx_s) begin
              state_nxt = DATA;
              s_nxt     = '0;
              n_nxt     = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            s_nxt = s + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == 5'd15) begin
            b_nxt = {rx_s, b[DBIT-1:1]};
            s_nxt = '0;
            if (n == NW'(DBIT - 1))
              state_nxt = PEN ? PARITY : STOP;
            else
              n_nxt = n + 1'b1;
          end else begin
            s_nxt = s + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s == 5'd15) begin
            p_nxt     = rx_s;
            s_nxt     = '0;
            state_nxt = STOP;
          end else begin
            s_nxt = s + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == 5'(SB_TICK - 1)) begin
            state_nxt = IDLE;
            dout_nxt  = b;
            done_nxt  = 1'b1;
            fe_nxt    = ~rx_s;
            pe_nxt    = PEN & ((^b ^ p) != PODD);
          end else begin
            s_nxt = s + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
